// File: rtl/ifu_sequencer.sv
// ifu_sequencer
// EX-stage sequencer for the integer functional units (ALU, MU, QRU, ...).
// It accepts one issued operation, sends a one-cycle start pulse to the
// selected functional unit (FU), and waits for that unit's done bit. It then
// captures the unit's result and destination register and offers them to
// write-back on a valid/ready handshake. There is a watchdog: an FU that never
// finishes moves the sequencer into a sticky error state.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   issue_valid/ready issue handshake; issue_fu selects the FU, issue_rd is
//                     the destination register
//   flush             synchronous abort of the in-flight operation
//   fu_start          one-hot start pulse, high for the first EXEC cycle only
//   fu_done, fu_res   per-FU done bits and results (FU k at [k*W +: W])
//   wb_valid/ready    write-back handshake carrying wb_data and wb_rd
//   busy              sequencer is not idle
//   err               sticky error: illegal FU index or watchdog timeout
module ifu_sequencer #(
  parameter int unsigned W       = 32,
  parameter int unsigned NFU     = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned SELW    = $clog2(NFU)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [SELW-1:0]   issue_fu,
  input  logic [4:0]        issue_rd,
  input  logic              flush,
  output logic [NFU-1:0]    fu_start,
  input  logic [NFU-1:0]    fu_done,
  input  logic [NFU*W-1:0]  fu_res,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [W-1:0]      wb_data,
  output logic [4:0]        wb_rd,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNTW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [4:0]        rd_q, rd_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [NFU-1:0]    start_q, start_d;
  logic              wb_valid_q, wb_valid_d;
  logic [W-1:0]      wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              err_q, err_d;

  logic              done_sel;
  logic [W-1:0]      res_sel;
  logic              issue_legal;
  logic [NFU-1:0]    start_onehot;
  logic              accept;

  // Index compared in 32 bits so non-power-of-two NFU values are caught.
  assign issue_legal  = ({{(32-SELW){1'b0}}, issue_fu} < NFU);
  assign start_onehot = NFU'(1) << issue_fu;

  // Selected unit's done/result; loop mux keeps out-of-range indices harmless.
  always_comb begin
    done_sel = 1'b0;
    res_sel  = '0;
    for (int unsigned k = 0; k < NFU; k++) begin
      if (sel_q == SELW'(k)) begin
        done_sel = fu_done[k];
        res_sel  = fu_res[k*W +: W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    start_d    = '0;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    err_d      = err_q;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (issue_valid) accept = 1'b1;
      end
      S_EXEC: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (done_sel) begin
          wb_data_d  = res_sel;
          wb_rd_d    = rd_q;
          wb_valid_d = 1'b1;
          state_d    = S_WB;
        end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        if (flush) begin
          wb_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else if (wb_ready) begin
          wb_valid_d = 1'b0;
          if (issue_valid) accept = 1'b1;
          else             state_d = S_IDLE;
        end
      end
      default: begin
        // S_ERR is left only through reset.
      end
    endcase

    // Shared by IDLE issue and back-to-back issue from WB.
    if (accept) begin
      sel_d = issue_fu;
      rd_d  = issue_rd;
      if (issue_legal) begin
        state_d = S_EXEC;
        cnt_d   = '0;
        start_d = start_onehot;
      end else begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      start_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      err_q      <= err_d;
    end
  end

  assign issue_ready = (state_q == S_IDLE) || ((state_q == S_WB) && wb_ready);
  assign busy        = (state_q != S_IDLE);
  assign fu_start    = start_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_rd       = wb_rd_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ifu_sequencer.sv
module tb_ifu_sequencer;
  localparam int W       = 32;
  localparam int NFU     = 4;
  localparam int TIMEOUT = 64;
  localparam int SELW    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid, issue_ready;
  logic [SELW-1:0]   issue_fu;
  logic [4:0]        issue_rd;
  logic              flush;
  logic [NFU-1:0]    fu_start, fu_done;
  logic [NFU*W-1:0]  fu_res;
  logic              wb_valid, wb_ready;
  logic [W-1:0]      wb_data;
  logic [4:0]        wb_rd;
  logic              busy, err;

  // Second build with three units for the illegal-index case.
  logic              iv3, ir3;
  logic [1:0]        ifu3;
  logic [4:0]        ird3;
  logic [2:0]        fs3;
  logic [3*W-1:0]    fr3;
  logic              wv3, busy3, err3;
  logic [W-1:0]      wd3;
  logic [4:0]        wr3;

  ifu_sequencer #(.W(W), .NFU(NFU), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_fu(issue_fu), .issue_rd(issue_rd), .flush(flush), .fu_start(fu_start),
    .fu_done(fu_done), .fu_res(fu_res), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .busy(busy), .err(err)
  );

  ifu_sequencer #(.W(W), .NFU(3), .TIMEOUT(TIMEOUT)) dut3 (
    .clk(clk), .rst(rst), .issue_valid(iv3), .issue_ready(ir3),
    .issue_fu(ifu3), .issue_rd(ird3), .flush(1'b0), .fu_start(fs3),
    .fu_done(3'b111), .fu_res(fr3), .wb_valid(wv3), .wb_ready(1'b1),
    .wb_data(wd3), .wb_rd(wr3), .busy(busy3), .err(err3)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected write-back results and expected start targets.
  typedef struct { logic [W-1:0] data; logic [4:0] rd; } wb_t;
  wb_t mon_e;
  wb_t exp_q[$];
  int  start_q[$];
  bit  err_ok = 1'b0;

  // FU behaviour: the targeted unit raises done 'lat' cycles after its start
  // pulse; every other unit shows random done/result noise.
  int            cur_fu  = -1;
  int            cur_lat = 0;
  logic [W-1:0]  cur_res = '0;
  int            age     = 1000;

  task automatic fu_model();
    for (int k = 0; k < NFU; k++) begin
      if (k == cur_fu) begin
        if (fu_start[k]) age = 0;
        else if (age < 100000) age++;
        fu_done[k]         = (age == cur_lat);
        fu_res[k*W +: W]   = cur_res;
      end else begin
        fu_done[k]         = 1'($urandom_range(0, 1));
        fu_res[k*W +: W]   = $urandom;
      end
    end
  endtask

  task automatic launch(input int fu, input logic [4:0] rd, input logic [W-1:0] res, input int lat);
    issue_valid = 1'b1;
    issue_fu    = SELW'(fu);
    issue_rd    = rd;
    cur_fu      = fu;
    cur_lat     = lat;
    cur_res     = res;
    age         = 1000;
    if (fu < NFU) begin
      start_q.push_back(fu);
      if (lat < TIMEOUT) exp_q.push_back('{res, rd});
    end
  endtask

  // One cycle of input drive, applied just after the rising edge.
  task automatic step(input bit fl, input bit wbr);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    flush       = fl;
    wb_ready    = wbr;
    fu_model();
    if (fl && busy && !err) exp_q.delete();
    #1;
  endtask

  function automatic int pick_lat();
    case ($urandom_range(0, 3))
      0:       return 0;
      1, 2:    return $urandom_range(1, 3);
      default: return $urandom_range(4, 40);
    endcase
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  bit           hold = 1'b0;
  logic [W-1:0] hd;
  logic [4:0]   hr;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (fu_start != '0) begin
        if (start_q.size() == 0) chk("start_unexpected", fu_start, 0);
        else chk("start_onehot", fu_start, 64'(1) << start_q.pop_front());
      end
      if (hold) begin
        chk("wb_hold_valid", wb_valid, 1);
        chk("wb_hold_data", wb_data, hd);
        chk("wb_hold_rd", wb_rd, hr);
      end
      if (wb_valid && wb_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", wb_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_data", wb_data, mon_e.data);
          chk("wb_rd", wb_rd, mon_e.rd);
        end
      end
      if (!err_ok) chk("err_clear", err, 0);
      hold = wb_valid && !wb_ready && !flush;
      hd   = wb_data;
      hr   = wb_rd;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "time limit");
  end

  initial begin
    int cyc;
    rst = 1'b1; issue_valid = 1'b0; issue_fu = '0; issue_rd = '0; flush = 1'b0;
    wb_ready = 1'b0; fu_done = '0; fu_res = '0;
    iv3 = 1'b0; ifu3 = '0; ird3 = '0; fr3 = {32'h33, 32'h22, 32'h11};

    // Reset state
    @(negedge clk);
    chk("rst_ready", issue_ready, 1); chk("rst_busy", busy, 0);
    chk("rst_wbv", wb_valid, 0); chk("rst_wbdata", wb_data, 0);
    chk("rst_wbrd", wb_rd, 0); chk("rst_start", fu_start, 0); chk("rst_err", err, 0);
    @(posedge clk); #3 rst = 1'b0;

    // Single-cycle FU0: wb_valid two cycles after issue
    step(0, 1); launch(0, 5'd5, 32'h7, 0);
    step(0, 1); @(negedge clk);
    chk("t1_start", fu_start, 4'b0001); chk("t1_wbv0", wb_valid, 0); chk("t1_busy1", busy, 1);
    step(0, 1); @(negedge clk);
    chk("t1_start_off", fu_start, 0); chk("t1_wbv", wb_valid, 1);
    chk("t1_data", wb_data, 32'h7); chk("t1_rd", wb_rd, 5); chk("t1_busy2", busy, 1);
    step(0, 1); @(negedge clk);
    chk("t1_idle", busy, 0); chk("t1_wbv_off", wb_valid, 0);

    // FU1 done 34 cycles after start, write-back stalled 3 cycles
    step(0, 0); launch(1, 5'd12, 32'hFFFF_FFFE, 34);
    for (int i = 1; i <= 40; i++) begin
      step(0, i >= 39);
      @(negedge clk);
      if (i < 39) chk("t2_ready", issue_ready, 0);
      chk("t2_wbv", wb_valid, (i >= 36 && i <= 39));
      if (i >= 36 && i <= 39) chk("t2_data", wb_data, 32'hFFFF_FFFE);
    end

    // Back-to-back issue from WB
    step(0, 1); launch(0, 5'd1, $urandom, 0);
    step(0, 1);
    step(0, 1); chk("t3_ready", issue_ready, 1); launch(2, 5'd9, 32'hABCD, 1);
    step(0, 1); @(negedge clk);
    chk("t3_start", fu_start, 4'b0100); chk("t3_wbv0", wb_valid, 0); chk("t3_busy", busy, 1);
    step(0, 1);
    step(0, 1); @(negedge clk);
    chk("t3_wbv", wb_valid, 1); chk("t3_rd", wb_rd, 9);
    step(0, 1);

    // Flush in the same cycle as done
    step(0, 1); launch(1, 5'd3, 32'h1234, 2);
    step(0, 1); step(0, 1); step(1, 1);
    step(0, 1); @(negedge clk); chk("t5_busy", busy, 0); chk("t5_wbv", wb_valid, 0);
    step(0, 1); @(negedge clk); chk("t5_wbv2", wb_valid, 0);
    step(0, 1); launch(0, 5'd4, 32'h55, 0);
    step(0, 1);
    step(0, 1); @(negedge clk); chk("t5_next_wbv", wb_valid, 1); chk("t5_next_data", wb_data, 32'h55);
    // Flush while idle does not block an issue
    step(1, 1); launch(3, 5'd6, 32'h66, 0);
    step(0, 1); @(negedge clk); chk("t5_idle_start", fu_start, 4'b1000);
    step(0, 1); @(negedge clk); chk("t5_idle_data", wb_data, 32'h66);
    step(0, 1);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      bit fl;
      fl = ($urandom_range(0, 24) == 0);
      step(fl, $urandom_range(0, 3) != 0);
      if (!(fl && busy) && issue_ready && $urandom_range(0, 2) != 0)
        launch($urandom_range(0, NFU - 1), 5'($urandom), $urandom, pick_lat());
    end
    for (int n = 0; n < 100 && (exp_q.size() != 0 || busy); n++) step(0, 1);
    @(negedge clk);
    chk("drain_busy", busy, 0);
    if (exp_q.size() != 0) chk("drain_pending", exp_q.size(), 0);

    // Watchdog timeout on FU3
    err_ok = 1'b1;
    step(0, 1); launch(3, 5'd7, 32'h0, 100000);
    cyc = 0;
    for (int i = 1; i <= 80; i++) begin
      step(0, 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (err) break;
      cyc++;
      chk("t4_ready_exec", issue_ready, 0);
    end
    chk("t4_exec_cycles", cyc, 64);
    chk("t4_err", err, 1); chk("t4_ready_err", issue_ready, 0); chk("t4_wbv", wb_valid, 0);
    step(1, 1); issue_valid = 1'b1; issue_fu = '0;
    step(0, 1); @(negedge clk);
    chk("t4_sticky", err, 1); chk("t4_nostart", fu_start, 0); chk("t4_ready_sticky", issue_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_err", err, 0); chk("t4_rst_wbv", wb_valid, 0); chk("t4_rst_start", fu_start, 0);
    chk("t4_rst_data", wb_data, 0); chk("t4_rst_rd", wb_rd, 0); chk("t4_rst_busy", busy, 0);
    chk("t4_rst_ready", issue_ready, 1);
    @(negedge clk); @(posedge clk); #3 rst = 1'b0;
    err_ok = 1'b0;
    step(0, 1); launch(2, 5'd10, 32'h77, 0);
    step(0, 1); step(0, 1); step(0, 1);

    // Three-unit build: legal op, then index 3 is illegal
    @(posedge clk); #1 chk("t6_ready", ir3, 1); iv3 = 1'b1; ifu3 = 2'd2; ird3 = 5'd8;
    @(posedge clk); #1 iv3 = 1'b0;
    @(negedge clk); chk("t6_start", fs3, 3'b100);
    @(negedge clk); chk("t6_wbv", wv3, 1); chk("t6_data", wd3, 32'h33); chk("t6_rd", wr3, 8);
    @(posedge clk); #1 iv3 = 1'b1; ifu3 = 2'd3;
    @(posedge clk); #1 iv3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_err", err3, 1); chk("t6_nostart", fs3, 0); chk("t6_ready_err", ir3, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_sequencer.md
Name: ifu_sequencer

Overview:
- Parametrised EX-stage sequencer for the integer functional unit (ALU, MU, QRU and future units).
- Accepts one issued operation, steers a one-cycle start pulse to the selected functional unit (FU) and waits for that unit's done signal.
- Captures the unit's result and destination register, then presents them to write-back on a valid/ready handshake.
- Generalises the fixed two-way ALU/MU result and done muxing to NFU units, and adds back-to-back issue, flush and a watchdog timeout.

Parameters:
- W, 32, datapath/result width in bits.
- NFU, 4, number of functional units (≥2).
- TIMEOUT, 64, max EXEC cycles before error (≥2).
- SELW, $clog2(NFU), FU select width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  operation offered.
- issue_ready  out  1  sequencer can accept.
- issue_fu  in  SELW  target FU index.
- issue_rd  in  5  destination register.
- flush  in  1  synchronous abort of the in-flight op.
- fu_start  out  NFU  one-hot start pulse.
- fu_done  in  NFU  per-FU done; combinational FUs tie their bit high.
- fu_res  in  NFU*W  concatenated results; FU k occupies [k*W +: W].
- wb_valid  out  1  result available.
- wb_ready  in  1  write-back accepts.
- wb_data  out  W  captured result.
- wb_rd  out  5  captured destination.
- busy  out  1  state != IDLE.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, any state, mid-op included) forces:
  - state=IDLE, fu_start=0, wb_valid=0, wb_data=0, wb_rd=0, err=0, timeout counter=0.
- FSM states:
  - IDLE: issue_ready=1. On issue_valid, latch issue_fu→sel and issue_rd→rd_q.
    - Legal sel → EXEC.
    - issue_fu ≥ NFU → ERR.
  - EXEC:
    - First cycle only: fu_start[sel]=1; all other start bits are 0 in every cycle.
    - fu_done[sel] is sampled every EXEC cycle, including the first. When it is 1, capture fu_res[sel] into wb_data and rd_q into wb_rd, then go to WB.
    - fu_done bits of non-selected units are ignored.
    - Counter increments each EXEC cycle. If the counter reaches TIMEOUT-1 with done still low, go to ERR at that edge.
  - WB: wb_valid=1; wb_data and wb_rd are held stable until the handshake.
    - wb_ready=1 completes the handshake.
    - issue_ready=wb_ready in this state. A simultaneous issue_valid goes straight to EXEC (back-to-back); otherwise go to IDLE.
  - ERR: err=1, issue_ready=0, wb_valid=0. Exit only by rst.
- Latency: for a FU with done tied high, issue accepted at edge 0, start and capture in cycle 1, wb_valid in cycle 2. Multi-cycle FU: wb_valid one cycle after the cycle in which done is sampled high.
- flush:
  - In EXEC or WB: next state IDLE, wb_valid drops, counter clears, and the captured result is discarded (never handed to write-back).
  - Flush has priority over done, over the WB handshake and over a new issue in the same cycle.
  - No effect in ERR or IDLE; an issue in IDLE with flush=1 is still accepted.
- Counter clears on every EXEC entry. Throughput is one op per 2 cycles minimum.
- Outputs are registered except issue_ready and busy, which are decoded from state (issue_ready also uses wb_ready in WB).

Test Plan:
- ALU-style FU0 (fu_done[0]=1, fu_res[0]=32'h0000_0007), issue fu=0 rd=5 → fu_start=4'b0001 for exactly one cycle; wb_valid two cycles after issue with wb_data=7, wb_rd=5; busy high until the handshake.
- FU1 asserts done 34 cycles after start with result 32'hFFFF_FFFE, wb_ready held low 3 cycles → wb_data stable at FFFF_FFFE for 4 cycles; issue_ready=0 throughout.
- Back-to-back: in WB with wb_ready=1, issue fu=2 rd=9 in the same cycle → next cycle fu_start=4'b0100, no IDLE cycle in between.
- FU3 never asserts done → err=1 after exactly TIMEOUT=64 EXEC cycles; issue_ready stays 0; rst (async, mid-cycle) clears err and all outputs immediately.
- flush asserted in the same cycle as fu_done[1]=1 → state IDLE, wb_valid never rises; a following issue completes normally.
- NFU=3 build, issue_fu=3 → err=1 and no fu_start pulse.
